// File: rtl/weight_pkg.sv
// Shared constants and row-slicing helper for the weight store.
// Word 0 of a row bus lives in the MSBs.
package weight_pkg;

   localparam int DATA_SIZE  = 16;
   localparam int SIZE       = 3;
   localparam int LAYER_SIZE = 5;
   localparam int IDX_W      = 32;

   // LSB position of word j in a row of n words of dw bits each
   function automatic int word_lsb(input int j, input int dw, input int n);
      return (n - 1 - j) * dw;
   endfunction

endpackage

// File: rtl/weight_row.sv
// One stored row of weights with write/update priority.
// Write beats update when both target this row.
module weight_row
   import weight_pkg::*;
#(
   parameter int data_size = DATA_SIZE,
   parameter int size      = SIZE
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic                      upd_en,
   input  logic [data_size*size-1:0] wr_data,
   input  logic [data_size*size-1:0] dc_dw,
   output logic [data_size*size-1:0] row
);

   logic [data_size*size-1:0] row_d;
   logic [data_size*size-1:0] row_q;

   // next row: write, else wrapping per-word subtract, else hold
   always_comb begin
      row_d = row_q;
      if (wr_en) begin
         row_d = wr_data;
      end else if (upd_en) begin
         for (int j = 0; j < size; j++) begin
            row_d[word_lsb(j, data_size, size) +: data_size] =
               row_q[word_lsb(j, data_size, size) +: data_size]
               - dc_dw[word_lsb(j, data_size, size) +: data_size];
         end
      end
   end

   // row register with synchronous clear
   always_ff @(posedge clk) begin
      if (reset) row_q <= '0;
      else       row_q <= row_d;
   end

   assign row = row_q;

endmodule

// File: rtl/weight_storage.sv
// Layered weight register file: update, read and write ports,
// each accepting one row operation per cycle.
module weight_storage
   import weight_pkg::*;
#(
   parameter int data_size  = DATA_SIZE,
   parameter int size       = SIZE,
   parameter int layer_size = LAYER_SIZE
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [IDX_W-1:0]          layer_index,
   input  logic [IDX_W-1:0]          row_index,
   input  logic [data_size*size-1:0] dc_dw,
   input  logic                      is_update,
   input  logic [IDX_W-1:0]          w_layer_index,
   input  logic [IDX_W-1:0]          w_row_index,
   input  logic                      is_read,
   output logic [data_size*size-1:0] w,
   input  logic [IDX_W-1:0]          write_layer_index,
   input  logic [IDX_W-1:0]          write_row_index,
   input  logic [data_size*size-1:0] write_data,
   input  logic                      is_write
);

   localparam int ROWS = layer_size * size;

   logic [data_size*size-1:0] rows [ROWS];
   logic [data_size*size-1:0] w_d;
   logic [data_size*size-1:0] w_q;
   logic                      wr_ok;
   logic                      upd_ok;

   // out-of-range writes and updates are dropped entirely
   assign wr_ok  = is_write
                 && (write_layer_index < IDX_W'(layer_size))
                 && (write_row_index < IDX_W'(size));
   assign upd_ok = is_update
                 && (layer_index < IDX_W'(layer_size))
                 && (row_index < IDX_W'(size));

   for (genvar l = 0; l < layer_size; l++) begin : g_layer
      for (genvar r = 0; r < size; r++) begin : g_row
         logic wr_en;
         logic upd_en;

         assign wr_en  = wr_ok
                       && (write_layer_index == IDX_W'(l))
                       && (write_row_index == IDX_W'(r));
         assign upd_en = upd_ok
                       && (layer_index == IDX_W'(l))
                       && (row_index == IDX_W'(r));

         weight_row #(
            .data_size (data_size),
            .size      (size)
         ) u_row (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en),
            .upd_en  (upd_en),
            .wr_data (write_data),
            .dc_dw   (dc_dw),
            .row     (rows[l*size+r])
         );
      end
   end

   // read mux: pre-edge contents, zero when the address is out of range
   always_comb begin
      w_d = w_q;
      if (is_read) begin
         w_d = '0;
         for (int l = 0; l < layer_size; l++) begin
            for (int r = 0; r < size; r++) begin
               if ((w_layer_index == IDX_W'(l))
                   && (w_row_index == IDX_W'(r))) begin
                  w_d = rows[l*size+r];
               end
            end
         end
      end
   end

   // read data register, holds while no read is requested
   always_ff @(posedge clk) begin
      if (reset) w_q <= '0;
      else       w_q <= w_d;
   end

   assign w = w_q;

endmodule

// File: tb/tb_weight_storage.sv
// Directed bench for weight_storage with a queue of expected
// read results popped one cycle after each read is issued.
module tb_weight_storage;

   localparam int DW = 16;
   localparam int N  = 3;
   localparam int L  = 5;
   localparam int RW = DW * N;

   logic          clk;
   logic          reset;
   logic [31:0]   layer_index;
   logic [31:0]   row_index;
   logic [RW-1:0] dc_dw;
   logic          is_update;
   logic [31:0]   w_layer_index;
   logic [31:0]   w_row_index;
   logic          is_read;
   logic [RW-1:0] w;
   logic [31:0]   write_layer_index;
   logic [31:0]   write_row_index;
   logic [RW-1:0] write_data;
   logic          is_write;

   logic [RW-1:0] sb [$];
   int            n_checks;
   int            n_fail;

   weight_storage #(DW, N, L) dut (
      .clk               (clk),
      .reset             (reset),
      .layer_index       (layer_index),
      .row_index         (row_index),
      .dc_dw             (dc_dw),
      .is_update         (is_update),
      .w_layer_index     (w_layer_index),
      .w_row_index       (w_row_index),
      .is_read           (is_read),
      .w                 (w),
      .write_layer_index (write_layer_index),
      .write_row_index   (write_row_index),
      .write_data        (write_data),
      .is_write          (is_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [RW-1:0] pk(input int a, input int b, input int c);
      return {a[15:0], b[15:0], c[15:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ops();
      is_update = 1'b0;
      is_write  = 1'b0;
      is_read   = 1'b0;
   endtask

   task automatic check_w(input string tag);
      logic [RW-1:0] exp;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL %s: scoreboard empty, w=%h", tag, w);
      end else begin
         exp = sb.pop_front();
         assert (w === exp) else begin
            n_fail++;
            $error("FAIL %s: w=%h expected %h", tag, w, exp);
         end
      end
   endtask

   task automatic set_wr(input int l, input int r, input logic [RW-1:0] d);
      write_layer_index = l;
      write_row_index   = r;
      write_data        = d;
      is_write          = 1'b1;
   endtask

   task automatic set_upd(input int l, input int r, input logic [RW-1:0] d);
      layer_index = l;
      row_index   = r;
      dc_dw       = d;
      is_update   = 1'b1;
   endtask

   // issues a read alongside whatever ops are already set up
   task automatic do_read(input int l, input int r,
                          input logic [RW-1:0] exp, input string tag);
      w_layer_index = l;
      w_row_index   = r;
      is_read       = 1'b1;
      sb.push_back(exp);
      tick();
      clear_ops();
      check_w(tag);
   endtask

   task automatic do_op();
      tick();
      clear_ops();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      clear_ops();
      layer_index = '0;
      row_index = '0;
      dc_dw = '0;
      w_layer_index = '0;
      w_row_index = '0;
      write_layer_index = '0;
      write_row_index = '0;
      write_data = '0;
      tick();
      reset = 1'b0;

      sb.push_back('0);
      check_w("reset_w");
      do_read(0, 0, '0, "rst_l0r0");
      do_read(4, 2, '0, "rst_l4r2");

      set_wr(1, 2, pk(100, -5, 7));
      do_op();
      do_read(1, 2, pk(100, -5, 7), "write");

      set_upd(1, 2, pk(10, -5, 8));
      do_op();
      do_read(1, 2, pk(90, 0, -1), "update");

      set_upd(1, 2, pk(-32768, 0, 0));
      do_op();
      do_read(1, 2, pk(-32678, 0, -1), "wrap");

      set_wr(2, 0, pk(1, 2, 3));
      set_upd(2, 0, pk(1, 1, 1));
      do_op();
      do_read(2, 0, pk(1, 2, 3), "wr_beats_upd");

      set_wr(2, 1, pk(4, 5, 6));
      set_upd(3, 1, pk(1, 2, 3));
      do_op();
      do_read(2, 1, pk(4, 5, 6), "both_wr");
      do_read(3, 1, pk(-1, -2, -3), "both_upd");

      set_wr(1, 2, pk(9, 9, 9));
      do_read(1, 2, pk(-32678, 0, -1), "rd_old");
      do_read(1, 2, pk(9, 9, 9), "rd_new");

      tick();
      sb.push_back(pk(9, 9, 9));
      check_w("hold");

      set_wr(5, 0, pk(7, 7, 7));
      do_op();
      set_wr(0, 3, pk(7, 7, 7));
      do_op();
      set_upd(5, 0, pk(1, 1, 1));
      do_op();
      do_read(1, 0, '0, "oor_l1r0");
      do_read(0, 0, '0, "oor_l0r0");
      do_read(4, 2, '0, "oor_l4r2");
      do_read(1, 2, pk(9, 9, 9), "pre_oor_rd");
      do_read(7, 0, '0, "rd_l7");
      do_read(1, 3, '0, "rd_r3");

      reset = 1'b1;
      set_wr(0, 1, pk(5, 5, 5));
      do_op();
      reset = 1'b0;
      do_read(0, 1, '0, "rst_wr");
      do_read(1, 2, '0, "rst_clr");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
